// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-register family: funsel encodings
// and the fill/full state used by ir_assembler.
package ir_pkg;

  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_DEC   = 2'b10;
  localparam logic [1:0] FS_INC   = 2'b11;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } ir_state_t;

endpackage

// File: rtl/ir_assembler_if.sv
// Bus between memory/control unit and ir_assembler: byte stream in,
// assembled instruction out, plus the funsel control.
interface ir_assembler_if #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 2
);
  localparam int PW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic                        enable;
  logic [1:0]                  funsel;
  logic [BYTE_W-1:0]           data;
  logic                        data_valid;
  logic                        data_ready;
  logic                        instr_ack;
  logic [BYTE_W*NUM_BYTES-1:0] irout;
  logic                        instr_valid;
  logic [PW-1:0]               byte_ptr;

  modport master (
    output enable, funsel, data, data_valid, instr_ack,
    input  data_ready, irout, instr_valid, byte_ptr
  );

  modport slave (
    input  enable, funsel, data, data_valid, instr_ack,
    output data_ready, irout, instr_valid, byte_ptr
  );
endinterface

// File: rtl/ir_assembler.sv
// Assembles a NUM_BYTES-wide instruction from a byte-serial stream and hands
// it to the control unit with an instr_valid/instr_ack handshake.
module ir_assembler
  import ir_pkg::*;
#(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 2,
  parameter int ENDIAN    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  ir_assembler_if.slave   bus
);

  localparam int IW = BYTE_W * NUM_BYTES;
  localparam int PW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_BYTES - 1);

  ir_state_t     state;
  logic [IW-1:0] ir;
  logic [PW-1:0] ptr;
  logic [PW-1:0] slot;
  int            slot_lsb;
  logic          accept;
  logic          do_clear;
  logic          do_step;

  // ENDIAN=1 fills from the most significant slot downward.
  always_comb begin
    slot     = (ENDIAN != 0) ? (LAST_PTR - ptr) : ptr;
    slot_lsb = int'(slot) * BYTE_W;
  end

  assign do_clear = bus.enable && (bus.funsel == FS_CLEAR);
  assign do_step  = bus.enable && ((bus.funsel == FS_INC) || (bus.funsel == FS_DEC));
  assign accept   = bus.enable && (bus.funsel == FS_LOAD) && bus.data_valid && (state == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      ir    <= '0;
      ptr   <= '0;
    end else if (do_clear) begin
      state <= FILL;
      ir    <= '0;
      ptr   <= '0;
    end else begin
      if (do_step) begin
        ir <= (bus.funsel == FS_INC) ? (ir + IW'(1)) : (ir - IW'(1));
      end else if (accept) begin
        ir[slot_lsb +: BYTE_W] <= bus.data;
        if (ptr == LAST_PTR) begin
          ptr   <= '0;
          state <= FULL;
        end else begin
          ptr <= ptr + PW'(1);
        end
      end
      // Accept only happens in FILL, so it never collides with this release.
      if (bus.instr_ack && (state == FULL)) begin
        state <= FILL;
        ptr   <= '0;
      end
    end
  end

  assign bus.irout       = ir;
  assign bus.byte_ptr    = ptr;
  assign bus.data_ready  = (state == FILL);
  assign bus.instr_valid = (state == FULL);

endmodule
